// File: rtl/rx_timer_pkg.sv
// Shared defaults and width helper for the receive bit-timing path.
package rx_timer_pkg;

  localparam int RX_CLKS_PER_BIT_DEF  = 8;
  localparam int RX_SAMPLE_PHASE_DEF  = 3;
  localparam int RX_BITS_PER_BYTE_DEF = 8;
  localparam int RX_STUFF_RUN_DEF     = 6;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int rx_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rx_phase_counter.sv
// Resynchronising modulo-CLKS_PER_BIT phase counter: clear wins, enable advances, else hold.
module rx_phase_counter
  import rx_timer_pkg::*;
#(
  parameter int CLKS_PER_BIT = RX_CLKS_PER_BIT_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic                                 enable,
  output logic [rx_cnt_width(CLKS_PER_BIT)-1:0] phase
);

  localparam int            PW   = rx_cnt_width(CLKS_PER_BIT);
  localparam logic [PW-1:0] LAST = PW'(CLKS_PER_BIT - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (enable) begin
      phase_d = (phase_q == LAST) ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/rx_bit_timer.sv
// Receive bit timer: sample-point strobe, bit/byte counting, optional stuffed-bit removal.
// Optional feature macro: RX_BIT_STUFF_EN (stuffed-bit drop and stuff_err).
module rx_bit_timer
  import rx_timer_pkg::*;
#(
  parameter int CLKS_PER_BIT  = RX_CLKS_PER_BIT_DEF,
  parameter int SAMPLE_PHASE  = RX_SAMPLE_PHASE_DEF,
  parameter int BITS_PER_BYTE = RX_BITS_PER_BYTE_DEF,
  parameter int STUFF_RUN     = RX_STUFF_RUN_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    d_edge,
  input  logic                                    rcving,
  input  logic                                    d_bit,
  output logic                                    shift_enable,
  output logic                                    byte_received,
  output logic [rx_cnt_width(BITS_PER_BYTE+1)-1:0] bit_count,
  output logic                                    stuff_err
);

  localparam int            PW         = rx_cnt_width(CLKS_PER_BIT);
  localparam int            CW         = rx_cnt_width(BITS_PER_BYTE + 1);
  localparam logic [PW-1:0] TICK_PHASE = PW'(SAMPLE_PHASE - 1);
  localparam logic [CW-1:0] LAST_BIT   = CW'(BITS_PER_BYTE - 1);

  generate
    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 64) begin : g_bad_cpb
      $error("rx_bit_timer: CLKS_PER_BIT must be 4..64");
    end
    if (SAMPLE_PHASE < 1 || SAMPLE_PHASE > CLKS_PER_BIT - 1) begin : g_bad_sp
      $error("rx_bit_timer: SAMPLE_PHASE must be 1..CLKS_PER_BIT-1");
    end
    if (BITS_PER_BYTE < 2 || BITS_PER_BYTE > 16) begin : g_bad_bpb
      $error("rx_bit_timer: BITS_PER_BYTE must be 2..16");
    end
  endgenerate

  logic [PW-1:0] phase;
  logic          sample_tick;
  logic          stuff_hit;
  logic          accept;
  logic          shift_q, shift_d;
  logic          byte_q, byte_d;
  logic [CW-1:0] count_q, count_d;

  rx_phase_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .clear (d_edge),
    .enable(rcving),
    .phase (phase)
  );

  // Next phase equals SAMPLE_PHASE exactly when the current phase is one below it.
  assign sample_tick = rcving && !d_edge && (phase == TICK_PHASE);

`ifdef RX_BIT_STUFF_EN
  localparam int            RW        = rx_cnt_width(STUFF_RUN + 1);
  localparam logic [RW-1:0] RUN_LIMIT = RW'(STUFF_RUN);

  logic [RW-1:0] ones_q, ones_d;
  logic          stuff_err_q, stuff_err_d;

  always_comb begin
    ones_d      = ones_q;
    stuff_hit   = 1'b0;
    stuff_err_d = 1'b0;
    if (!rcving) begin
      ones_d = '0;
    end else if (sample_tick) begin
      if (ones_q == RUN_LIMIT) begin
        stuff_hit   = 1'b1;
        ones_d      = '0;
        stuff_err_d = d_bit;
      end else if (d_bit) begin
        ones_d = ones_q + 1'b1;
      end else begin
        ones_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q      <= '0;
      stuff_err_q <= 1'b0;
    end else begin
      ones_q      <= ones_d;
      stuff_err_q <= stuff_err_d;
    end
  end

  assign stuff_err = stuff_err_q;
`else
  logic unused_stuff_cfg;

  assign stuff_hit        = 1'b0;
  assign stuff_err        = 1'b0;
  assign unused_stuff_cfg = d_bit ^ STUFF_RUN[0];
`endif

  assign accept = sample_tick && !stuff_hit;

  // Counting follows the registered strobe so the byte pulse lands one cycle after the last shift.
  always_comb begin
    shift_d = accept;
    byte_d  = 1'b0;
    count_d = count_q;
    if (!rcving) begin
      count_d = '0;
    end else if (shift_q) begin
      if (count_q == LAST_BIT) begin
        count_d = '0;
        byte_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= 1'b0;
      byte_q  <= 1'b0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      byte_q  <= byte_d;
      count_q <= count_d;
    end
  end

  assign shift_enable  = shift_q;
  assign byte_received = byte_q;
  assign bit_count     = count_q;

endmodule
